// File: rtl/bug_spawn_ctrl.sv
// Spawn sequencer: seeds the game LFSR, draws spawn coordinates, rejects repeats of the
// previous coordinate and offers the result over valid/ready with a frame-based cooldown.
module bug_spawn_ctrl #(
  parameter int unsigned COOLDOWN_FRAMES = 30,
  parameter int unsigned MAX_RETRY       = 3,
  parameter int unsigned CNT_W           = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        frame,
  input  logic        spawn_req,
  input  logic [14:0] rand_in,
  output logic        lfsr_advance,
  output logic        lfsr_ld,
  output logic [7:0]  lfsr_din,
  output logic [14:0] spawn_x,
  output logic        spawn_valid,
  input  logic        spawn_ready,
  output logic        busy
);

  localparam int unsigned RetryW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  typedef enum logic [2:0] {
    StIdle,
    StSeed,
    StWaitReq,
    StAdv,
    StSample,
    StOffer
  } state_e;

  state_e              state_q, state_d;
  logic [7:0]          seed_cnt_q;
  logic [14:0]         last_x_q, last_x_d;
  logic [14:0]         spawn_x_q, spawn_x_d;
  logic                pending_q, pending_d;
  logic [RetryW-1:0]   retry_q, retry_d;
  logic [CNT_W-1:0]    cool_q, cool_d;
  logic                service;
  logic                dup_retry;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      seed_cnt_q <= 8'd0;
      last_x_q   <= 15'd0;
      spawn_x_q  <= 15'd0;
      pending_q  <= 1'b0;
      retry_q    <= '0;
      cool_q     <= '0;
    end else begin
      state_q    <= state_d;
      seed_cnt_q <= seed_cnt_q + 8'd1;
      last_x_q   <= last_x_d;
      spawn_x_q  <= spawn_x_d;
      pending_q  <= pending_d;
      retry_q    <= retry_d;
      cool_q     <= cool_d;
    end
  end

  assign service   = (spawn_req || pending_q) && (cool_q == '0);
  assign dup_retry = (rand_in == last_x_q) && (retry_q < RetryW'(MAX_RETRY));

  always_comb begin
    state_d   = state_q;
    last_x_d  = last_x_q;
    spawn_x_d = spawn_x_q;
    pending_d = pending_q;
    retry_d   = retry_q;
    cool_d    = cool_q;

    // Requests that cannot be serviced right now are remembered, one deep.
    if (spawn_req && (state_q inside {StAdv, StSample, StOffer})) begin
      pending_d = 1'b1;
    end

    if (start) begin
      // Restart aborts any offer; last_x and cool survive so the rules still apply.
      state_d   = StSeed;
      pending_d = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: ;
        StSeed: state_d = StWaitReq;
        StWaitReq: begin
          if (service) begin
            pending_d = 1'b0;
            retry_d   = '0;
            state_d   = StAdv;
          end else begin
            if (spawn_req) pending_d = 1'b1;
            if ((cool_q != '0) && frame) cool_d = cool_q - 1'b1;
          end
        end
        StAdv: state_d = StSample;
        StSample: begin
          if (dup_retry) begin
            retry_d = retry_q + 1'b1;
            state_d = StAdv;
          end else begin
            spawn_x_d = rand_in;
            state_d   = StOffer;
          end
        end
        StOffer: begin
          if (spawn_ready) begin
            last_x_d = spawn_x_q;
            cool_d   = CNT_W'(COOLDOWN_FRAMES);
            state_d  = StWaitReq;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    lfsr_ld      = (state_q == StSeed);
    lfsr_din     = 8'd0;
    if (state_q == StSeed) begin
      // An all-zero seed would lock the LFSR.
      lfsr_din = (seed_cnt_q == 8'd0) ? 8'h01 : seed_cnt_q;
    end
    lfsr_advance = (state_q == StAdv);
    spawn_valid  = (state_q == StOffer);
    spawn_x      = spawn_x_q;
    busy         = !(state_q inside {StIdle, StWaitReq});
  end

endmodule

// File: tb/tb_bug_spawn_ctrl.sv
// Directed bench for bug_spawn_ctrl: seeding, spawn latency, cooldown, duplicate retry,
// backpressure, abort and reset.
module tb_bug_spawn_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        frame = 1'b0;
  logic        spawn_req = 1'b0;
  logic [14:0] rand_in = 15'd0;
  logic        lfsr_advance;
  logic        lfsr_ld;
  logic [7:0]  lfsr_din;
  logic [14:0] spawn_x;
  logic        spawn_valid;
  logic        spawn_ready = 1'b1;
  logic        busy;

  int n_checks = 0;
  int n_pass   = 0;
  int cnt      = 0;   // model of seed_cnt
  int adv_cnt  = 0;
  int hs_cnt   = 0;

  bug_spawn_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .frame        (frame),
    .spawn_req    (spawn_req),
    .rand_in      (rand_in),
    .lfsr_advance (lfsr_advance),
    .lfsr_ld      (lfsr_ld),
    .lfsr_din     (lfsr_din),
    .spawn_x      (spawn_x),
    .spawn_valid  (spawn_valid),
    .spawn_ready  (spawn_ready),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    if (spawn_valid && spawn_ready) hs_cnt++;
    @(posedge clk);
    #1;
    cnt = (cnt + 1) % 256;
    if (lfsr_advance) adv_cnt++;
  endtask

  task automatic pulse_frames(input int n);
    for (int i = 0; i < n; i++) begin
      frame = 1'b1;
      tick();
      frame = 1'b0;
      tick();
    end
  endtask

  // Request a spawn; rand_in shows dup until n_dup advances have happened, then fresh.
  task automatic run_spawn(input logic [14:0] dup, input logic [14:0] fresh, input int n_dup,
                           output int lat, output int advs);
    int a0;
    a0 = adv_cnt;
    rand_in = (n_dup == 0) ? fresh : dup;
    spawn_req = 1'b1;
    tick();
    spawn_req = 1'b0;
    lat = 1;
    while (!spawn_valid && lat < 40) begin
      if (adv_cnt - a0 >= n_dup) rand_in = fresh;
      tick();
      lat++;
    end
    advs = adv_cnt - a0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, advs, a0, h0, stable;
    logic [7:0] exp_din;

    // Reset
    #1;
    tick();
    tick();
    cnt = 0;
    reset = 1'b0;
    check("rst_ld", lfsr_ld, 1'b0);
    check("rst_din", lfsr_din, 8'd0);
    check("rst_adv", lfsr_advance, 1'b0);
    check("rst_valid", spawn_valid, 1'b0);
    check("rst_x", spawn_x, 15'd0);
    check("rst_busy", busy, 1'b0);

    // IDLE ignores spawn requests
    spawn_req = 1'b1;
    tick();
    spawn_req = 1'b0;
    tick();
    tick();
    check("idle_no_adv", adv_cnt, 0);

    // 1. Seeding at seed_cnt = 0x5A
    while (((cnt + 1) % 256) != 8'h5A) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("seed_ld", lfsr_ld, 1'b1);
    check("seed_din", lfsr_din, 8'h5A);
    check("seed_busy", busy, 1'b1);
    tick();
    check("seed_ld_drop", lfsr_ld, 1'b0);
    check("wait_busy", busy, 1'b0);

    // 2. Zero seed
    while (((cnt + 1) % 256) != 0) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("zseed_ld", lfsr_ld, 1'b1);
    check("zseed_din", lfsr_din, 8'h01);
    tick();

    // 3. Basic spawn
    spawn_ready = 1'b1;
    rand_in = 15'h00C4;
    spawn_req = 1'b1;
    tick();
    spawn_req = 1'b0;
    check("b_adv_p1", lfsr_advance, 1'b1);
    check("b_valid_p1", spawn_valid, 1'b0);
    tick();
    check("b_adv_p2", lfsr_advance, 1'b0);
    tick();
    check("b_valid_p3", spawn_valid, 1'b1);
    check("b_x", spawn_x, 15'h00C4);
    tick();
    check("b_valid_drop", spawn_valid, 1'b0);
    check("b_hs", hs_cnt, 1);

    // 4. Cooldown and pending (two requests during cooldown -> one spawn)
    a0 = adv_cnt;
    rand_in = 15'h1234;
    spawn_req = 1'b1;
    tick();
    spawn_req = 1'b0;
    check("cd_no_adv", lfsr_advance, 1'b0);
    check("cd_busy", busy, 1'b0);
    tick();
    spawn_req = 1'b1;
    tick();
    spawn_req = 1'b0;
    pulse_frames(29);
    check("cd_29_no_adv", adv_cnt - a0, 0);
    frame = 1'b1;
    tick();
    frame = 1'b0;
    check("cd_30_adv_lo", lfsr_advance, 1'b0);
    tick();
    check("cd_adv_after", lfsr_advance, 1'b1);
    h0 = hs_cnt;
    repeat (10) tick();
    check("cd_one_hs", hs_cnt - h0, 1);
    a0 = adv_cnt;
    pulse_frames(30);
    repeat (5) tick();
    check("cd_no_second", adv_cnt - a0, 0);

    // 5. Duplicate reject: last_x = 0x1234, two duplicate samples then 0x0555
    run_spawn(15'h1234, 15'h0555, 3, lat, advs);
    check("dup_advs", advs, 3);
    check("dup_lat", lat, 7);
    check("dup_x", spawn_x, 15'h0555);
    tick();
    pulse_frames(30);
    // Stuck on last_x: duplicate accepted after MAX_RETRY retries
    run_spawn(15'h0555, 15'h0555, 100, lat, advs);
    check("stuck_advs", advs, 4);
    check("stuck_lat", lat, 9);
    check("stuck_x", spawn_x, 15'h0555);
    tick();
    pulse_frames(30);

    // 6. Backpressure
    spawn_ready = 1'b0;
    run_spawn(15'h2AAA, 15'h2AAA, 0, lat, advs);
    check("bp_lat", lat, 3);
    stable = 0;
    rand_in = 15'h7FFF;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (spawn_valid && spawn_x == 15'h2AAA) stable++;
    end
    check("bp_stable", stable, 10);
    // Abort mid-offer
    start = 1'b1;
    tick();
    start = 1'b0;
    exp_din = (cnt == 0) ? 8'h01 : 8'(cnt);
    check("abort_valid", spawn_valid, 1'b0);
    check("abort_ld", lfsr_ld, 1'b1);
    check("abort_din", lfsr_din, exp_din);
    tick();
    // Offer again, then reset mid-offer
    run_spawn(15'h3333, 15'h3333, 0, lat, advs);
    check("re_valid", spawn_valid, 1'b1);
    check("re_x", spawn_x, 15'h3333);
    reset = 1'b1;
    tick();
    check("rr_ld", lfsr_ld, 1'b0);
    check("rr_din", lfsr_din, 8'd0);
    check("rr_adv", lfsr_advance, 1'b0);
    check("rr_valid", spawn_valid, 1'b0);
    check("rr_x", spawn_x, 15'd0);
    check("rr_busy", busy, 1'b0);
    reset = 1'b0;
    spawn_ready = 1'b1;
    tick();
    check("rr_idle_valid", spawn_valid, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/bug_spawn_ctrl.md
Name: bug_spawn_ctrl

Overview:
- Sequencer that seeds and drives the 8-bit game LFSR wrapper (moddedLFSR: advance, LD, Din in; 15-bit randOut back).
- Turns game spawn requests into validated spawn coordinates, offered to the bug object logic over a valid/ready handshake.
- Sits between the game FSM (start, spawn requests, frame tick) and the bug sprite registers.
- Enforces a frame-based cooldown and rejects a repeat of the previous coordinate.

Parameters:
- COOLDOWN_FRAMES, 30, frame ticks to wait after a completed handshake before the next request is serviced.
- MAX_RETRY, 3, extra LFSR advances allowed when a sample equals the previous coordinate.
- CNT_W, 5, width of the cooldown counter; must satisfy 2^CNT_W > COOLDOWN_FRAMES.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; game start, triggers LFSR seeding.
- frame  in  1  one-cycle pulse per video frame.
- spawn_req  in  1  one-cycle pulse requesting a new bug.
- rand_in  in  15  randOut from the LFSR wrapper.
- lfsr_advance  out  1  to LFSR advance.
- lfsr_ld  out  1  to LFSR LD.
- lfsr_din  out  8  to LFSR Din.
- spawn_x  out  15  offered coordinate.
- spawn_valid  out  1  spawn_x valid.
- spawn_ready  in  1  consumer accepts.
- busy  out  1  high in any state other than IDLE or WAIT_REQ.

Behaviour:
- Reset values:
  - state = IDLE.
  - All outputs 0; spawn_x = 15'd0.
  - seed_cnt = 0, last_x = 0, pending = 0, retry = 0, cool = 0.
- seed_cnt:
  - 8-bit counter, increments every cycle in every state.
  - Wraps 255 -> 0.
- IDLE:
  - On start, go to SEED.
  - spawn_req is ignored; pending stays 0.
- SEED (1 cycle):
  - lfsr_ld = 1, lfsr_din = seed_cnt.
  - If seed_cnt == 0, lfsr_din = 8'h01 instead, to avoid LFSR lock-up.
  - Next state: WAIT_REQ.
- WAIT_REQ:
  - Service condition: (spawn_req or pending) and cool == 0.
  - When the service condition holds: clear pending, set retry = 0, go to ADV.
  - If cool != 0, decrement cool on each frame pulse.
- ADV (1 cycle): lfsr_advance = 1, then go to SAMPLE.
- SAMPLE (1 cycle): rand_in is stable after the advance edge and is registered into a candidate.
  - If candidate == last_x and retry < MAX_RETRY: retry++, go to ADV.
  - Otherwise: spawn_x = candidate, go to OFFER.
  - Once MAX_RETRY is reached, the duplicate is accepted.
- OFFER:
  - spawn_valid = 1; spawn_x is held stable until the handshake.
  - On spawn_valid && spawn_ready: last_x = spawn_x, cool = COOLDOWN_FRAMES, spawn_valid drops next cycle, go to WAIT_REQ.
- Pending requests:
  - A spawn_req arriving in ADV, SAMPLE or OFFER, or in WAIT_REQ while cool != 0, sets pending.
  - Pending is one deep; further requests while pending = 1 are dropped.
- start outside IDLE: go to SEED immediately and abort any offer.
  - spawn_valid = 0 and pending = 0.
  - last_x and cool are preserved.
- frame pulses: only decrement cool in WAIT_REQ; ignored in all other states.
- Latency: with cool == 0, a spawn_req in WAIT_REQ gives spawn_valid = 1 exactly 3 cycles later when there is no retry (WAIT_REQ -> ADV -> SAMPLE -> OFFER). Each retry adds 2 cycles.
- Reset mid-operation: return to the reset values within the same edge. An outstanding offer is discarded.
- spawn_x is passed through unmodified from rand_in; no range check is performed.

Test Plan:
1. Seeding: reset, run until seed_cnt = 8'h5A, pulse start -> lfsr_ld = 1, lfsr_din = 8'h5A for one cycle; state = WAIT_REQ, busy = 0.
2. Zero seed: pulse start when seed_cnt = 0 -> lfsr_din = 8'h01.
3. Basic spawn: cool = 0, pulse spawn_req with spawn_ready = 1 ->
   - lfsr_advance at +1; spawn_valid at +3.
   - spawn_x = rand_in sampled in SAMPLE (e.g. 15'h00C4).
   - spawn_valid low after the accept cycle.
4. Cooldown and pending:
   - Complete a spawn, then pulse spawn_req immediately -> no advance.
   - After 30 frame pulses -> advance on the following cycle.
   - A second spawn_req during cooldown is not queued twice: only one spawn occurs.
5. Duplicate reject: force rand_in = last_x for 2 samples, then a new value ->
   - 3 advance pulses total.
   - Offered value is the new value.
   - With rand_in stuck equal to last_x: MAX_RETRY + 1 = 4 advances, then the duplicate is offered.
6. Backpressure and abort:
   - spawn_ready = 0 for 10 cycles -> spawn_valid and spawn_x stable throughout.
   - Pulse start mid-offer -> spawn_valid = 0 next cycle, lfsr_ld = 1.
   - Pulse reset -> all outputs 0.
